// File: rtl/fpadd_issue.sv
// fpadd_issue: operand FIFO and latency-aligned issue tracker for fpadd_single.
// Define FPADD_ISSUE_SPECIAL_EN to build the NaN/Inf/zero flag classifier and pipe.
module fpadd_issue #(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_A,
  input  logic [31:0]              in_B,
  input  logic                     issue_en,
  output logic [31:0]              reg_A,
  output logic [31:0]              reg_B,
  input  logic [31:0]              add_out,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  output logic [2:0]               res_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ADD_LAT-1:0] vpipe;
  logic               push;
  logic               pop;

  assign in_ready = count < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = issue_en && (count != '0);

  assign res_valid = vpipe[ADD_LAT-1];
  assign res_data  = add_out;

  // Storage carries no reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_A, in_B};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      reg_A  <= '0;
      reg_B  <= '0;
      vpipe  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        reg_A  <= mem[rd_ptr][63:32];
        reg_B  <= mem[rd_ptr][31:0];
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      vpipe <= ADD_LAT'({vpipe, pop});
    end
  end

`ifdef FPADD_ISSUE_SPECIAL_EN
  logic [2:0] fpipe [ADD_LAT];
  logic [2:0] head_flags;
  logic [31:0] head_a;
  logic [31:0] head_b;

  function automatic logic [2:0] classify(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    a_zero = (a[30:0] == 31'h0);
    b_zero = (b[30:0] == 31'h0);
    return {a_nan | b_nan, a_inf | b_inf, a_zero & b_zero};
  endfunction

  assign head_a     = mem[rd_ptr][63:32];
  assign head_b     = mem[rd_ptr][31:0];
  assign head_flags = classify(head_a, head_b);

  // Idle slots carry zero so flags are only ever set alongside res_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        fpipe[i] <= '0;
      end
    end else begin
      fpipe[0] <= pop ? head_flags : 3'b000;
      for (int i = 1; i < ADD_LAT; i++) begin
        fpipe[i] <= fpipe[i-1];
      end
    end
  end

  assign res_flags = fpipe[ADD_LAT-1];
`else
  assign res_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fpadd_issue.sv
// tb_fpadd_issue: random and directed stimulus for fpadd_issue against a
// queue-based reference model, with a behavioural stand-in for fpadd_single.
module tb_fpadd_issue;

  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 2;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          issue_en = 1'b0;
  logic [31:0]   in_A = '0;
  logic [31:0]   in_B = '0;
  logic [31:0]   add_out;
  logic          in_ready;
  logic          res_valid;
  logic [31:0]   reg_A;
  logic [31:0]   reg_B;
  logic [31:0]   res_data;
  logic [2:0]    res_flags;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  fpadd_issue #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_A     (in_A),
    .in_B     (in_B),
    .issue_en (issue_en),
    .reg_A    (reg_A),
    .reg_B    (reg_B),
    .add_out  (add_out),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_flags(res_flags),
    .count    (count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int unsigned ia;
    int unsigned ib;
    bit          fin;
  } pair_t;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [2:0]  f;
    bit          fin;
  } res_t;

  pair_t src[$];
  pair_t fq[$];
  res_t  rq[$];
  int    cyc = 0;
  int    errs = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] i2f(input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    m = (32'(v) << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] f);
    int p;
    logic [31:0] m;
    if (f[30:23] == 8'h0) return 0;
    p = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return m >> (23 - p);
  endfunction

  // Stand-in adder: integer-valued operands only; any Inf/NaN gives qNaN.
  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    return i2f(f2i(a) + f2i(b));
  endfunction

  function automatic logic [2:0] cls(input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef FPADD_ISSUE_SPECIAL_EN
    bit an, bn, ai, bi, az, bz;
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    az = a[30:0] == 0;
    bz = b[30:0] == 0;
    return {an | bn, ai | bi, az & bz};
`else
    return 3'b000;
`endif
  endfunction

  logic [31:0] apipe [ADD_LAT-1] = '{default: 32'h0};
  always @(posedge clk) begin
    apipe[0] <= fadd(reg_A, reg_B);
    for (int i = 1; i < ADD_LAT - 1; i++) apipe[i] <= apipe[i-1];
  end
  assign add_out = apipe[ADD_LAT-2];

  function automatic pair_t mk(input int unsigned x, input int unsigned y);
    pair_t p;
    p.a = i2f(x); p.b = i2f(y); p.ia = x; p.ib = y; p.fin = 1'b1;
    return p;
  endfunction

  function automatic pair_t sp(input logic [31:0] a, input logic [31:0] b);
    pair_t p;
    p.a = a; p.b = b; p.ia = 0; p.ib = 0; p.fin = 1'b0;
    return p;
  endfunction

  function automatic pair_t rnd_pair();
    logic [31:0] s;
    if ($urandom_range(0, 9) == 0) begin
      case ($urandom_range(0, 4))
        0: s = 32'h7FC0_0000;
        1: s = 32'h7F80_0000;
        2: s = 32'hFF80_0000;
        3: s = 32'h7FFF_FFFF;
        default: s = 32'h8000_0000;
      endcase
      return sp(s, i2f($urandom_range(0, 1000)));
    end
    return mk($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
  endfunction

  // Reference model: FIFO as a queue, results tagged with their due cycle.
  always @(posedge clk) begin
    pair_t p;
    bit do_pop;
    bit do_push;
    if (reset) begin
      cyc++;
      do_pop  = issue_en && fq.size() != 0;
      do_push = in_valid && fq.size() < DEPTH;
      if (do_pop) begin
        p = fq.pop_front();
        rq.push_back('{cyc + ADD_LAT - 1, i2f(p.ia + p.ib), cls(p.a, p.b),
                       p.fin});
      end
      if (do_push && src.size() != 0) fq.push_back(src.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset && src.size() != 0) begin
      in_valid = 1'b1;
      in_A = src[0].a;
      in_B = src[0].b;
    end else begin
      in_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    res_t r;
    bit exp_v;
    if (reset) begin
      check("count", 32'(count), 32'(fq.size()));
      check("in_ready", 32'(in_ready), 32'(fq.size() < DEPTH));
      exp_v = rq.size() != 0 && rq[0].due == cyc;
      check("res_valid", 32'(res_valid), 32'(exp_v));
      if (exp_v) begin
        r = rq.pop_front();
        if (r.fin) check("res_data", res_data, r.d);
        check("res_flags", 32'(res_flags), 32'(r.f));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    issue_en = 1'b1;
    for (int i = 0; i < 200 && (src.size() != 0 || fq.size() != 0 ||
         rq.size() != 0); i++) step();
    check("drain", 32'(src.size() + fq.size() + rq.size()), 32'h0);
  endtask

  initial begin
    repeat (2) step();
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_reg_A", reg_A, 32'h0);
    check("rst_reg_B", reg_B, 32'h0);
    check("rst_res_flags", 32'(res_flags), 32'h0);
    check("rst_res_data", res_data, add_out);
    reset = 1'b1;
    step();

    issue_en = 1'b1;
    src.push_back(mk(1, 2));
    wait_drain();
    check("hold_reg_A", reg_A, 32'h3F80_0000);
    check("hold_reg_B", reg_B, 32'h4000_0000);

    issue_en = 1'b0;
    for (int k = 0; k < 5; k++) src.push_back(mk(k + 3, 7));
    repeat (8) step();
    check("full_count", 32'(count), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("held_5th", 32'(src.size()), 32'h1);
    wait_drain();

    src.push_back(sp(32'h7FC0_0000, 32'h3F80_0000));
    src.push_back(sp(32'h7F80_0000, 32'h3F80_0000));
    src.push_back(sp(32'h8000_0000, 32'h0000_0000));
    wait_drain();

    issue_en = 1'b0;
    src.push_back(mk(10, 20));
    src.push_back(mk(11, 21));
    repeat (4) step();
    issue_en = 1'b1;
    for (int k = 0; k < 6; k++) src.push_back(mk(100 + k, 5));
    step();
    step();
    check("simul_count", 32'(count), 32'h2);
    wait_drain();

    for (int k = 0; k < 10; k++) src.push_back(mk(k, 1));
    for (int n = 0; n < 30; n++) begin
      issue_en = n[0];
      step();
    end
    wait_drain();

    for (int n = 0; n < 400; n++) begin
      if (src.size() < 2 && $urandom_range(0, 2) != 0) src.push_back(rnd_pair());
      issue_en = $urandom_range(0, 3) != 0;
      step();
    end
    wait_drain();

    issue_en = 1'b0;
    for (int k = 0; k < 5; k++) src.push_back(mk(k + 40, 2));
    repeat (6) step();
    issue_en = 1'b1;
    step();
    step();
    issue_en = 1'b0;
    check("pre_rst_res_valid", 32'(res_valid), 32'h1);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    src.delete();
    fq.delete();
    rq.delete();
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'h0);
    check("mid_rst_count", 32'(count), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    repeat (2) step();
    reset = 1'b1;
    repeat (5) step();
    src.push_back(mk(5, 6));
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fpadd_issue.md
# fpadd_issue

Upstream issue stage for `fpadd_single`. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. When enabled, it issues one pair per cycle onto the adder's `reg_A`/`reg_B` inputs. It also tracks each issued pair through the adder's fixed latency, so the adder's `out` is presented downstream with an aligned `res_valid` and optional special-operand flags.

## Interface
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `ADD_LAT`, default 2: cycles from the `reg_A`/`reg_B` update edge to a valid adder `out`; ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset).
- `in_valid`, in, 1: operand pair offered.
- `in_ready`, out, 1: FIFO can accept.
- `in_A`, in, 32: IEEE-754 single operand A.
- `in_B`, in, 32: IEEE-754 single operand B.
- `issue_en`, in, 1: permit a pop/issue this cycle (adder throttle).
- `reg_A`, out, 32: registered operand A, connects to `fpadd_single.reg_A`.
- `reg_B`, out, 32: registered operand B, connects to `fpadd_single.reg_B`.
- `add_out`, in, 32: `fpadd_single.out`.
- `res_valid`, out, 1: `res_data` holds the result of an issued pair.
- `res_data`, out, 32: equals `add_out`, combinational passthrough.
- `res_flags`, out, 3: {any NaN, any Inf, both zero} of the issued pair.
- `count`, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push occurs when `in_valid && in_ready`; `in_ready = (count < DEPTH)`. There is no same-cycle pass-through: a full FIFO stays not-ready even if a pop happens in that cycle.
- Pop/issue occurs when `issue_en && count != 0`:
  - The head is loaded into `reg_A`/`reg_B`.
  - A 1 is shifted into the ADD_LAT-deep valid pipe.
  - Otherwise `reg_A`/`reg_B` hold their values and a 0 is shifted in.
- `res_valid = vpipe[ADD_LAT-1]`.
- The FIFO has no bypass: an entry pushed at edge t can issue at edge t+1 at the earliest.
- Simultaneous push and pop: `count` is unchanged and FIFO order is preserved.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` disambiguates full from empty.
- No result backpressure: the downstream consumer must accept whenever `res_valid` = 1.
- Flags are computed from the popped operands at issue time and carried in a pipe parallel to the valid pipe:
  - NaN: exponent = FF and mantissa ≠ 0.
  - Inf: exponent = FF and mantissa = 0.
  - Zero: exponent = 0 and mantissa = 0, either sign.

## Timing
- Reset (asynchronous, `reset` = 0) values:
  - Pointers, `count`, valid pipe, flag pipe: 0.
  - `reg_A`, `reg_B`: 32'h0.
  - `res_valid`: 0.
  - `res_flags`: 0.
  - `in_ready`: 1.
  - `res_data` still follows `add_out`.
- Reset mid-operation: all buffered and in-flight pairs are discarded, and `res_valid` drops immediately without waiting for a clock edge. No stale `res_valid` appears after release.
- Issue latency: a pop at edge t updates `reg_A`/`reg_B` at t. `res_valid` = 1 during the cycle after edge t+ADD_LAT−1, i.e. for exactly one cycle per issued pair.
- Back-to-back issues produce back-to-back `res_valid` pulses in issue order.
- `in_ready` and `count` are registered-state derived, so they are glitch-free within a cycle.

## Configuration
- `FPADD_ISSUE_SPECIAL_EN` defined: the flag classifier and the ADD_LAT×3 flag pipe are built, and `res_flags` is valid whenever `res_valid` = 1.
- Not defined: no classifier and no flag pipe are built, and `res_flags` is constant 3'b000.
- All other behaviour is identical in both builds.

## Test plan
- Single pair, `issue_en` = 1: push A = 3F800000, B = 40000000 → `reg_A`/`reg_B` update on the next edge. `res_valid` is a 1-cycle pulse ADD_LAT cycles later with `res_data` = 40400000 and `res_flags` = 000.
- Fill with `issue_en` = 0, DEPTH = 4: offer 5 pairs → 4 accepted, `count` = 4, `in_ready` = 0 and the 5th is held. Raising `issue_en` → `in_ready` = 1 the cycle after the first pop.
- Special operands (macro on): 7FC00000 + 3F800000 → `res_flags` = 100. Then 7F800000 + 3F800000 → 010. Then 80000000 + 00000000 → 001. Each flag is aligned with its `res_valid`. With the macro off, all three give 000.
- Simultaneous push/pop at `count` = 2 → `count` stays 2. Results emerge in push order.
- Wrap: stream 10 pairs (k×1.0 + 1.0, k = 0..9) with `issue_en` toggling 1/0 → 10 `res_valid` pulses, in order, values correct.
- Reset mid-flight: drop `reset` with 2 pairs in the pipe and 3 in the FIFO → `res_valid` = 0, `count` = 0, `in_ready` = 1 immediately. After release, no `res_valid` occurs until a new issue.
